// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the programmable sequence detector.
// Holds mode encodings, reset pattern defaults and the length clamp.
package seq_detect_pkg;

  localparam logic OVERLAP     = 1'b1;
  localparam logic NON_OVERLAP = 1'b0;

  localparam logic [7:0] DEF_RESET_PAT = 8'b0000_1011;
  localparam int         DEF_RESET_LEN = 4;

  // Out-of-range lengths fall back to the full pattern width.
  function automatic int clamp_len(input int len, input int pat_w);
    return (len < 1 || len > pat_w) ? pat_w : len;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Ports: clk, rst_n (async low), inc_i, clr_i, cnt_o[W-1:0].
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && cnt_q != {W{1'b1}}) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector with overlap mode and match counter.
// Ports: clk, rst (async low), in, in_valid, pat_load, pat_data, pat_len,
//   overlap_en, clr_cnt -> match (1-cycle pulse), match_cnt, fill.
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W     = 8,
  parameter int               CNT_W     = 8,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(DEF_RESET_PAT),
  parameter int               RESET_LEN = DEF_RESET_LEN,
  localparam int              LEN_W     = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_data,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap_en,
  input  logic             clr_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [LEN_W-1:0] fill
);

  localparam logic [LEN_W-1:0] RST_LEN =
    LEN_W'(clamp_len(RESET_LEN, PAT_W));

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             match_q;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] len_d;
  logic             hit;

  // Match is judged on next-state history/fill so the
  // pulse lands exactly one cycle after the completing bit.
  always_comb begin
    hist_d = (hist_q << 1) | PAT_W'(in);
    fill_d = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
    mask   = ~({PAT_W{1'b1}} << len_q);
    len_d  = LEN_W'(clamp_len(int'(pat_len), PAT_W));
    hit    = in_valid && !pat_load && (fill_d == len_q) &&
             (((hist_d ^ pat_q) & mask) == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q   <= RESET_PAT;
      len_q   <= RST_LEN;
      ovl_q   <= OVERLAP;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else if (pat_load) begin
      pat_q   <= pat_data;
      len_q   <= len_d;
      ovl_q   <= overlap_en;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else if (in_valid) begin
      hist_q  <= hist_d;
      // Non-overlap restarts the fill so old bits cannot complete a match.
      fill_q  <= (hit && ovl_q == NON_OVERLAP) ? '0 : fill_d;
      match_q <= hit;
    end else begin
      match_q <= 1'b0;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc_i (hit),
    .clr_i (clr_cnt || pat_load),
    .cnt_o (match_cnt)
  );

  assign match = match_q;
  assign fill  = fill_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed testbench for seq_detect_prog.
// Uses CNT_W=2 so counter saturation is reachable quickly.
module tb_seq_detect_prog;

  localparam int PAT_W = 8;
  localparam int CNT_W = 2;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             din = 1'b0;
  logic             in_valid = 1'b0;
  logic             pat_load = 1'b0;
  logic [PAT_W-1:0] pat_data = '0;
  logic [LEN_W-1:0] pat_len = '0;
  logic             overlap_en = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic [LEN_W-1:0] fill;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  seq_detect_prog #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (din),
    .in_valid   (in_valid),
    .pat_load   (pat_load),
    .pat_data   (pat_data),
    .pat_len    (pat_len),
    .overlap_en (overlap_en),
    .clr_cnt    (clr_cnt),
    .match      (match),
    .match_cnt  (match_cnt),
    .fill       (fill)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l,
                      input logic ov);
    pat_load = 1'b1; pat_data = p; pat_len = l; overlap_en = ov;
    tick();
    pat_load = 1'b0;
  endtask

  task automatic feed(input logic b);
    din = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    vecs++;
    if (match !== 1'b0) begin
      errs++; $display("FAIL rst_match got %b want 0", match);
    end
    vecs++;
    if (match_cnt !== 2'd0) begin
      errs++; $display("FAIL rst_cnt got %0d want 0", match_cnt);
    end
    vecs++;
    if (fill !== 4'd0) begin
      errs++; $display("FAIL rst_fill got %0d want 0", fill);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    vecs++;
    if (fill !== 4'd0 || match !== 1'b0) begin
      errs++; $display("FAIL rst_idle got fill=%0d m=%b want 0/0", fill, match);
    end
  endtask

  task automatic test_default_overlap();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] em   = 7'b0001001;
    int ec[7] = '{0, 0, 0, 1, 1, 1, 2};
    for (int i = 0; i < 7; i++) begin
      feed(bits[6-i]);
      vecs++;
      if (match !== em[6-i]) begin
        errs++; $display("FAIL t1_match bit%0d got %b want %b", i+1, match, em[6-i]);
      end
      vecs++;
      if (match_cnt !== CNT_W'(ec[i])) begin
        errs++; $display("FAIL t1_cnt bit%0d got %0d want %0d", i+1, match_cnt, ec[i]);
      end
    end
  endtask

  task automatic test_non_overlap();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] em   = 7'b0001000;
    int ef[7] = '{1, 2, 3, 0, 1, 2, 3};
    load(8'b1011, 4'd4, 1'b0);
    vecs++;
    if (match_cnt !== 2'd0 || fill !== 4'd0 || match !== 1'b0) begin
      errs++; $display("FAIL t2_load got cnt=%0d fill=%0d m=%b want 0/0/0",
                       match_cnt, fill, match);
    end
    for (int i = 0; i < 7; i++) begin
      feed(bits[6-i]);
      vecs++;
      if (match !== em[6-i]) begin
        errs++; $display("FAIL t2_match bit%0d got %b want %b", i+1, match, em[6-i]);
      end
      vecs++;
      if (fill !== LEN_W'(ef[i])) begin
        errs++; $display("FAIL t2_fill bit%0d got %0d want %0d", i+1, fill, ef[i]);
      end
    end
    vecs++;
    if (match_cnt !== 2'd1) begin
      errs++; $display("FAIL t2_cnt got %0d want 1", match_cnt);
    end
  endtask

  task automatic test_all_ones();
    logic [4:0] emo = 5'b00111;
    logic [4:0] emn = 5'b00100;
    int eco[5] = '{0, 0, 1, 2, 3};
    int efn[5] = '{1, 2, 0, 1, 2};
    load(8'b111, 4'd3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      feed(1'b1);
      vecs++;
      if (match !== emo[4-i] || match_cnt !== CNT_W'(eco[i])) begin
        errs++; $display("FAIL t3_ovl bit%0d got m=%b c=%0d want m=%b c=%0d",
                         i+1, match, match_cnt, emo[4-i], eco[i]);
      end
    end
    load(8'b111, 4'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      feed(1'b1);
      vecs++;
      if (match !== emn[4-i] || fill !== LEN_W'(efn[i])) begin
        errs++; $display("FAIL t3_novl bit%0d got m=%b f=%0d want m=%b f=%0d",
                         i+1, match, fill, emn[4-i], efn[i]);
      end
    end
    vecs++;
    if (match_cnt !== 2'd1) begin
      errs++; $display("FAIL t3_novl_cnt got %0d want 1", match_cnt);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] bits = 4'b1011;
    load(8'b1011, 4'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      feed(bits[3-i]);
      vecs++;
      if (match !== (i == 3) || fill !== LEN_W'(i+1)) begin
        errs++; $display("FAIL t4_bit%0d got m=%b f=%0d want m=%b f=%0d",
                         i+1, match, fill, (i == 3), i+1);
      end
      for (int g = 0; g < 2; g++) begin
        tick();
        vecs++;
        if (match !== 1'b0 || fill !== LEN_W'(i+1)) begin
          errs++; $display("FAIL t4_gap%0d.%0d got m=%b f=%0d want m=0 f=%0d",
                           i+1, g, match, fill, i+1);
        end
      end
    end
    vecs++;
    if (match_cnt !== 2'd1) begin
      errs++; $display("FAIL t4_cnt got %0d want 1", match_cnt);
    end
  endtask

  task automatic test_saturate();
    logic [2:0] nb = 3'b010;
    logic [2:0] nm = 3'b101;
    int nf[3] = '{0, 1, 0};
    logic [7:0] a5 = 8'hA5;
    logic [3:0] lens[2] = '{4'd0, 4'd12};
    load(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      feed(1'b1);
      vecs++;
      if (match !== 1'b1 || match_cnt !== CNT_W'((i < 3) ? i+1 : 3)) begin
        errs++; $display("FAIL t5_sat bit%0d got m=%b c=%0d want m=1 c=%0d",
                         i+1, match, match_cnt, (i < 3) ? i+1 : 3);
      end
    end
    clr_cnt = 1'b1;
    feed(1'b1);
    clr_cnt = 1'b0;
    vecs++;
    if (match !== 1'b1 || match_cnt !== 2'd0) begin
      errs++; $display("FAIL t5_clr got m=%b c=%0d want m=1 c=0", match, match_cnt);
    end
    feed(1'b0);
    vecs++;
    if (match !== 1'b0 || match_cnt !== 2'd0) begin
      errs++; $display("FAIL t5_zero got m=%b c=%0d want m=0 c=0", match, match_cnt);
    end
    load(8'h00, 4'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      feed(nb[2-i]);
      vecs++;
      if (match !== nm[2-i] || fill !== LEN_W'(nf[i])) begin
        errs++; $display("FAIL t5_l1novl bit%0d got m=%b f=%0d want m=%b f=%0d",
                         i+1, match, fill, nm[2-i], nf[i]);
      end
    end
    for (int k = 0; k < 2; k++) begin
      load(8'hA5, lens[k], 1'b1);
      for (int i = 0; i < 8; i++) begin
        feed(a5[7-i]);
        vecs++;
        if (match !== (i == 7) || fill !== LEN_W'(i+1)) begin
          errs++; $display("FAIL t5_clamp len%0d bit%0d got m=%b f=%0d want m=%b f=%0d",
                           lens[k], i+1, match, fill, (i == 7), i+1);
        end
      end
      feed(1'b0);
      vecs++;
      if (match !== 1'b0 || fill !== 4'd8) begin
        errs++; $display("FAIL t5_fillsat len%0d got m=%b f=%0d want m=0 f=8",
                         lens[k], match, fill);
      end
    end
  endtask

  task automatic test_midstream();
    logic [3:0] bits = 4'b1011;
    logic [3:0] alt  = 4'b0110;
    load(8'b1011, 4'd4, 1'b1);
    for (int i = 0; i < 3; i++) feed(bits[3-i]);
    pat_load = 1'b1; pat_data = 8'b1011; pat_len = 4'd4; overlap_en = 1'b1;
    din = 1'b1; in_valid = 1'b1;
    tick();
    pat_load = 1'b0; in_valid = 1'b0;
    vecs++;
    if (fill !== 4'd0 || match !== 1'b0) begin
      errs++; $display("FAIL t6_load got f=%0d m=%b want 0/0", fill, match);
    end
    for (int i = 0; i < 4; i++) begin
      feed(bits[3-i]);
      vecs++;
      if (match !== (i == 3) || fill !== LEN_W'(i+1)) begin
        errs++; $display("FAIL t6_fresh bit%0d got m=%b f=%0d want m=%b f=%0d",
                         i+1, match, fill, (i == 3), i+1);
      end
    end
    load(8'b0110, 4'd4, 1'b1);
    for (int i = 0; i < 4; i++) feed(alt[3-i]);
    vecs++;
    if (match !== 1'b1 || match_cnt !== 2'd1) begin
      errs++; $display("FAIL t6_pre got m=%b c=%0d want m=1 c=1", match, match_cnt);
    end
    #2;
    rst = 1'b0;
    #1;
    vecs++;
    if (match !== 1'b0 || match_cnt !== 2'd0 || fill !== 4'd0) begin
      errs++; $display("FAIL t6_async got m=%b c=%0d f=%0d want 0/0/0",
                       match, match_cnt, fill);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      feed(bits[3-i]);
      vecs++;
      if (match !== (i == 3) || fill !== LEN_W'(i+1)) begin
        errs++; $display("FAIL t6_post bit%0d got m=%b f=%0d want m=%b f=%0d",
                         i+1, match, fill, (i == 3), i+1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_overlap();
    test_non_overlap();
    test_all_ones();
    test_gaps();
    test_saturate();
    test_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
